// File: rtl/hazard_scheduler.sv
// Interlock and forwarding scheduler for a five-stage MIPS pipeline.
// Tracks the EX/MEM destinations in flight and drives stall, bubble, flush, forward and event counters.
module hazard_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [4:0]       id_dst,
    input  logic             id_branch_taken,
    input  logic             mem_busy,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    logic             ex_v_q,    ex_v_d;
    logic             ex_wreg_q, ex_wreg_d;
    logic             ex_m2reg_q, ex_m2reg_d;
    logic [4:0]       ex_dst_q,  ex_dst_d;
    logic             mem_v_q,    mem_v_d;
    logic             mem_wreg_q, mem_wreg_d;
    logic             mem_m2reg_q, mem_m2reg_d;
    logic [4:0]       mem_dst_q,  mem_dst_d;
    logic [CNT_W-1:0] load_stall_cnt_q, load_stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_stall, issue;

    function automatic logic stage_hit(input logic v, input logic wreg,
                                       input logic [4:0] dst, input logic [4:0] r);
        return v & wreg & (dst == r) & (r != 5'd0);
    endfunction

    // A loading EX hit is never forwarded from EX; it either stalls or falls back to MEM.
    function automatic logic [1:0] fwd_sel(input logic use_r, input logic stall,
                                           input logic ex_h, input logic ex_ld,
                                           input logic mem_h, input logic mem_ld);
        logic [1:0] sel;
        sel = 2'b00;
        if (!use_r || stall) begin
            sel = 2'b00;
        end else if (ex_h && !ex_ld) begin
            sel = 2'b01;
        end else if (mem_h) begin
            sel = mem_ld ? 2'b11 : 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (c != {CNT_W{1'b1}})) begin
            r = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = c;
        end
        return r;
    endfunction

    always_comb begin
        ex_hit_rs  = stage_hit(ex_v_q, ex_wreg_q, ex_dst_q, id_rs);
        ex_hit_rt  = stage_hit(ex_v_q, ex_wreg_q, ex_dst_q, id_rt);
        mem_hit_rs = stage_hit(mem_v_q, mem_wreg_q, mem_dst_q, id_rs);
        mem_hit_rt = stage_hit(mem_v_q, mem_wreg_q, mem_dst_q, id_rt);
        load_stall = id_valid & ((id_use_rs & ex_hit_rs) | (id_use_rt & ex_hit_rt)) & ex_m2reg_q;
        issue      = id_valid & ~load_stall;

        fwda = fwd_sel(id_use_rs, load_stall, ex_hit_rs, ex_m2reg_q, mem_hit_rs, mem_m2reg_q);
        fwdb = fwd_sel(id_use_rt, load_stall, ex_hit_rt, ex_m2reg_q, mem_hit_rt, mem_m2reg_q);

        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
        end else if (load_stall) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            ifid_flush  = id_valid & id_branch_taken;
        end

        ex_v_d      = ex_v_q;
        ex_wreg_d   = ex_wreg_q;
        ex_m2reg_d  = ex_m2reg_q;
        ex_dst_d    = ex_dst_q;
        mem_v_d     = mem_v_q;
        mem_wreg_d  = mem_wreg_q;
        mem_m2reg_d = mem_m2reg_q;
        mem_dst_d   = mem_dst_q;
        if (!mem_busy) begin
            mem_v_d     = ex_v_q;
            mem_wreg_d  = ex_wreg_q;
            mem_m2reg_d = ex_m2reg_q;
            mem_dst_d   = ex_dst_q;
            ex_v_d      = issue;
            ex_wreg_d   = id_wreg;
            ex_m2reg_d  = id_m2reg;
            ex_dst_d    = id_dst;
        end else begin
            ex_v_d      = ex_v_q;
        end

        load_stall_cnt_d = sat_inc(load_stall_cnt_q, load_stall & ~mem_busy);
        flush_cnt_d      = sat_inc(flush_cnt_q, ifid_flush);
        freeze_cnt_d     = sat_inc(freeze_cnt_q, mem_busy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_q           <= 1'b0;
            ex_wreg_q        <= 1'b0;
            ex_m2reg_q       <= 1'b0;
            ex_dst_q         <= 5'd0;
            mem_v_q          <= 1'b0;
            mem_wreg_q       <= 1'b0;
            mem_m2reg_q      <= 1'b0;
            mem_dst_q        <= 5'd0;
            load_stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q      <= {CNT_W{1'b0}};
            freeze_cnt_q     <= {CNT_W{1'b0}};
        end else begin
            ex_v_q           <= ex_v_d;
            ex_wreg_q        <= ex_wreg_d;
            ex_m2reg_q       <= ex_m2reg_d;
            ex_dst_q         <= ex_dst_d;
            mem_v_q          <= mem_v_d;
            mem_wreg_q       <= mem_wreg_d;
            mem_m2reg_q      <= mem_m2reg_d;
            mem_dst_q        <= mem_dst_d;
            load_stall_cnt_q <= load_stall_cnt_d;
            flush_cnt_q      <= flush_cnt_d;
            freeze_cnt_q     <= freeze_cnt_d;
        end
    end

    assign load_stall_cnt = load_stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;
    assign freeze_cnt     = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized scoreboard bench for hazard_scheduler; the reference keeps the in-flight
// instructions as a two-entry list and derives controls from the hazard rules directly.
module tb_hazard_scheduler;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_branch_taken, mem_busy;
    logic [4:0] id_rs, id_rt, id_dst;
    logic pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0] fwda, fwdb;
    logic [CW-1:0] load_stall_cnt, flush_cnt, freeze_cnt;

    hazard_scheduler #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_dst(id_dst), .id_branch_taken(id_branch_taken), .mem_busy(mem_busy),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .pipe_freeze(pipe_freeze), .fwda(fwda), .fwdb(fwdb),
        .load_stall_cnt(load_stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    typedef struct {
        int pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_freeze;
        int fwda, fwdb, lsc, fc, frc;
    } exp_t;

    typedef struct {
        bit v;
        bit wreg;
        bit ld;
        int dst;
    } slot_t;

    exp_t  exp_q[$];
    slot_t pipe[2];   // [0] = instruction in EX, [1] = instruction in MEM
    int    m_lsc, m_fc, m_frc;
    int    tests, fails;

    function automatic bit writes_reg(slot_t s, int r);
        return s.v && s.wreg && (s.dst == r) && (r != 0);
    endfunction

    function automatic int fwd_of(bit use_r, bit stall, int r);
        if (!use_r || stall) return 0;
        if (writes_reg(pipe[0], r) && !pipe[0].ld) return 1;
        if (writes_reg(pipe[1], r)) return pipe[1].ld ? 3 : 2;
        return 0;
    endfunction

    function automatic int bump(int c);
        return (c < CMAX) ? c + 1 : CMAX;
    endfunction

    task automatic check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle with a queued expectation is compared.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc_wen", int'(pc_wen), e.pc_wen);
            check("ifid_wen", int'(ifid_wen), e.ifid_wen);
            check("ifid_flush", int'(ifid_flush), e.ifid_flush);
            check("idex_bubble", int'(idex_bubble), e.idex_bubble);
            check("pipe_freeze", int'(pipe_freeze), e.pipe_freeze);
            check("fwda", int'(fwda), e.fwda);
            check("fwdb", int'(fwdb), e.fwdb);
            check("load_stall_cnt", int'(load_stall_cnt), e.lsc);
            check("flush_cnt", int'(flush_cnt), e.fc);
            check("freeze_cnt", int'(freeze_cnt), e.frc);
        end
    end

    initial begin
        exp_t e;
        bit stall;
        int rs, rt;
        tests = 0; fails = 0;
        m_lsc = 0; m_fc = 0; m_frc = 0;
        for (int i = 0; i < 2; i++) pipe[i] = '{v: 1'b0, wreg: 1'b0, ld: 1'b0, dst: 0};
        rst = 1'b1; id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_wreg = 1'b0;
        id_m2reg = 1'b0; id_branch_taken = 1'b0; mem_busy = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_dst = 5'd0;
        repeat (2) @(posedge clk);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst             = (c > 0) && ($urandom_range(0, 149) == 0);
            mem_busy        = ($urandom_range(0, 4) == 0);
            id_valid        = ($urandom_range(0, 5) != 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = ($urandom_range(0, 3) == 0) ? id_rs : 5'($urandom_range(0, 3));
            id_use_rs       = ($urandom_range(0, 3) != 0);
            id_use_rt       = ($urandom_range(0, 2) != 0);
            id_wreg         = ($urandom_range(0, 4) != 0);
            id_m2reg        = ($urandom_range(0, 2) == 0);
            id_dst          = 5'($urandom_range(0, 3));
            id_branch_taken = ($urandom_range(0, 4) == 0);

            rs = int'(id_rs);
            rt = int'(id_rt);
            stall = id_valid && pipe[0].ld &&
                    ((id_use_rs && writes_reg(pipe[0], rs)) || (id_use_rt && writes_reg(pipe[0], rt)));

            e.fwda = fwd_of(id_use_rs, stall, rs);
            e.fwdb = fwd_of(id_use_rt, stall, rt);
            e.lsc = m_lsc; e.fc = m_fc; e.frc = m_frc;
            if (mem_busy) begin
                e.pipe_freeze = 1; e.pc_wen = 0; e.ifid_wen = 0; e.ifid_flush = 0; e.idex_bubble = 0;
            end else if (stall) begin
                e.pipe_freeze = 0; e.pc_wen = 0; e.ifid_wen = 0; e.ifid_flush = 0; e.idex_bubble = 1;
            end else begin
                e.pipe_freeze = 0; e.pc_wen = 1; e.ifid_wen = 1; e.idex_bubble = 0;
                e.ifid_flush = (id_valid && id_branch_taken) ? 1 : 0;
            end
            exp_q.push_back(e);

            if (rst) begin
                pipe[0].v = 1'b0; pipe[1].v = 1'b0;
                m_lsc = 0; m_fc = 0; m_frc = 0;
            end else if (mem_busy) begin
                m_frc = bump(m_frc);
            end else begin
                if (stall) m_lsc = bump(m_lsc);
                if (e.ifid_flush == 1) m_fc = bump(m_fc);
                pipe[1] = pipe[0];
                pipe[0] = '{v: id_valid && !stall, wreg: id_wreg, ld: id_m2reg, dst: int'(id_dst)};
            end
        end

        repeat (2) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline interlock and forwarding scheduler for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It sits beside the decode stage, keeps its own shadow record of the destination registers in flight in EX and MEM, and drives the stall, bubble, flush and forwarding-select controls for the PC, IF/ID and ID/EX registers. It also maintains saturating performance counters for load-use stalls, taken-branch flushes and memory freezes.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- id_rs, id_rt  in  5 each  source register fields of the ID instruction
- id_use_rs, id_use_rt  in  1 each  instruction reads rs / rt
- id_wreg  in  1  instruction writes the register file
- id_m2reg  in  1  instruction is a load
- id_dst  in  5  destination register (rd or rt, already selected by Regrt)
- id_branch_taken  in  1  branch resolved taken in ID this cycle
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- pc_wen  out  1  PC write enable
- ifid_wen  out  1  IF/ID write enable
- ifid_flush  out  1  load a NOP into IF/ID at the next edge
- idex_bubble  out  1  load a bubble into ID/EX instead of the ID instruction
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold
- fwda, fwdb  out  2 each  operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
- load_stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  saturating event counters

## Operation
- Shadow state: ex_v, ex_wreg, ex_m2reg, ex_dst; mem_v, mem_wreg, mem_m2reg, mem_dst.
- Match definitions: ex_hit(r) = ex_v & ex_wreg & (ex_dst == r) & (r != 0). mem_hit(r) is defined the same way using the mem_* fields.
- load_stall = id_valid & ((id_use_rs & ex_hit(id_rs)) | (id_use_rt & ex_hit(id_rt))) & ex_m2reg.
- issue = id_valid & ~load_stall.
- Forwarding for fwda (fwdb is identical with rt):
  - 00 if ~id_use_rs or load_stall.
  - 01 if ex_hit(rs) and ~ex_m2reg.
  - Otherwise, if mem_hit(rs): 11 when mem_m2reg, else 10.
  - Otherwise 00.
  - EX has priority over MEM.
  - WB needs no forwarding path; the register file writes before it reads in the same cycle.
- Freeze (mem_busy = 1):
  - pipe_freeze = 1, pc_wen = 0, ifid_wen = 0, ifid_flush = 0, idex_bubble = 0.
  - Shadow state holds.
- Load-use stall (mem_busy = 0, load_stall = 1):
  - pc_wen = 0, ifid_wen = 0, idex_bubble = 1, ifid_flush = 0.
  - A taken branch is ignored this cycle; it is re-evaluated after the stall.
- Normal operation (mem_busy = 0, load_stall = 0):
  - pc_wen = 1, ifid_wen = 1, idex_bubble = 0.
  - ifid_flush = id_valid & id_branch_taken.
- Shadow update at each non-frozen edge:
  - mem_* <= ex_*.
  - ex_* <= {issue, id_wreg, id_m2reg, id_dst}; ex_v is 0 when the stage is bubbled.
- Counters saturate at all-ones and never wrap. Each increments at most once per cycle:
  - load_stall_cnt on a cycle that is stalled but not frozen.
  - flush_cnt when ifid_flush = 1.
  - freeze_cnt when mem_busy = 1.

## Timing
- Every control output is combinational from the current inputs and shadow registers. Outputs are valid in the same cycle, with no latency.
- A load-use hazard costs exactly one bubble. On the next cycle the load sits in MEM, and the dependent instruction gets fwd = 11.
- A taken branch costs one flushed slot.
- Reset values, applied at the clk edge with rst = 1:
  - All shadow valid bits are 0 and all counters are 0.
  - Hence fwda = fwdb = 00, pc_wen = 1, ifid_wen = 1, idex_bubble = 0, ifid_flush = 0 (when id_valid = 0), and pipe_freeze = mem_busy.
- rst wins over mem_busy. A reset asserted mid-stall or mid-freeze clears the shadow state on that edge.
- Register $0 never produces a hit, a forward or a stall.
- If id_rs == id_rt and both are used, fwda and fwdb are equal.

## Test plan
- ADD $1 in EX, then SUB $2,$1,$3 in ID -> fwda = 01, no stall. One cycle later (ADD in MEM, unrelated instruction in ID reading $1) -> fwda = 10.
- LW $4 in EX, then ADD $5,$4,$4 in ID -> for one cycle pc_wen = 0, ifid_wen = 0, idex_bubble = 1, and load_stall_cnt goes 0 to 1. Next cycle -> fwda = fwdb = 11, no stall.
- LW $0 in EX, then a reader of $0 -> no stall and fwda = 00.
- Taken BEQ in ID with no hazard -> ifid_flush = 1 and flush_cnt = 1. The same BEQ with a load-use hazard on rs -> first cycle stalls with no flush, second cycle flushes.
- mem_busy held for 3 cycles with LW in EX and a dependent instruction in ID -> pipe_freeze = 1, load_stall_cnt unchanged, freeze_cnt = 3, shadow state held. After release -> the one-cycle stall proceeds.
- Preload the counters near all-ones with CNT_W = 4 and hold the load-use condition for 20 cycles -> load_stall_cnt reaches 15 and stays at 15. Assert rst during a freeze -> all counters 0 and shadow valid bits 0 at the next edge.
